// File: rtl/nios_pio_pkg.sv
// Shared register map and field widths for the LED PWM/blink output port.
package nios_pio_pkg;

  // Word addresses of the slave registers
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_DUTY     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  // Global brightness register and PWM counter width
  localparam int unsigned DUTY_W = 8;

  // Full-scale duty means "always on", so the last counter slot is not lost
  localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

  // PWM gate for the current counter value
  function automatic logic pwm_gate(input logic [DUTY_W-1:0] cnt, input logic [DUTY_W-1:0] duty);
    return (cnt < duty) || (duty == DUTY_FULL);
  endfunction

endpackage

// File: rtl/nios_led_tick.sv
// Blink timebase: down-counter that reloads from PRESCALE and toggles the blink phase on
// each underflow. A direct load restarts the count without touching the phase.
module nios_led_tick #(
  parameter int unsigned PRESCALE_W    = 24,
  parameter int unsigned PRESCALE_INIT = 24999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] load_value,
  input  logic [PRESCALE_W-1:0] reload_value,
  output logic                  phase
);

  localparam logic [PRESCALE_W-1:0] CntInit = PRESCALE_W'(PRESCALE_INIT);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  // Next count and phase: load wins over the regular reload/decrement
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q == '0) begin
      cnt_d   = reload_value;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and phase state, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= CntInit;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/nios_led_pwm.sv
// Avalon-MM LED output port: WIDTH channels with set/clear access, a global 8-bit brightness
// PWM and per-channel blink. Zero-wait-state slave; reads are combinational, side-effect free.
module nios_led_pwm
  import nios_pio_pkg::*;
#(
  parameter int unsigned       WIDTH         = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
  parameter int unsigned       PRESCALE_INIT = 24999,
  parameter int unsigned       PRESCALE_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PRESCALE_W-1:0] PrescaleInit = PRESCALE_W'(PRESCALE_INIT);

  logic                  wr_en;
  logic                  prescale_wr;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [DUTY_W-1:0]     duty_q, duty_d;
  logic [DUTY_W-1:0]     pwm_cnt_q;
  logic [WIDTH-1:0]      out_q;
  logic                  pwm_on;
  logic                  blink_phase;
  logic                  unused_wd;

  assign wr_en       = chipselect & ~write_n;
  assign prescale_wr = wr_en && (address == ADDR_PRESCALE);

  // High writedata bits beyond each register are intentionally ignored
  assign unused_wd = ^writedata;

  // Register write decode
  always_comb begin
    data_d     = data_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d     = writedata[WIDTH-1:0];
        ADDR_MODE:     mode_d     = writedata[WIDTH-1:0];
        ADDR_PRESCALE: prescale_d = writedata[PRESCALE_W-1:0];
        ADDR_DUTY:     duty_d     = writedata[DUTY_W-1:0];
        ADDR_OUTSET:   data_d     = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLR:   data_d     = data_q & ~writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      mode_q     <= '0;
      prescale_q <= PrescaleInit;
      duty_q     <= DUTY_FULL;
    end else begin
      data_q     <= data_d;
      mode_q     <= mode_d;
      prescale_q <= prescale_d;
      duty_q     <= duty_d;
    end
  end

  // Free-running PWM counter, wraps naturally at 255
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign pwm_on = pwm_gate(pwm_cnt_q, duty_q);

  // Blink timebase; a PRESCALE write restarts the half-period immediately
  nios_led_tick #(
    .PRESCALE_W    (PRESCALE_W),
    .PRESCALE_INIT (PRESCALE_INIT)
  ) u_tick (
    .clk          (clk),
    .reset        (reset),
    .load         (prescale_wr),
    .load_value   (writedata[PRESCALE_W-1:0]),
    .reload_value (prescale_q),
    .phase        (blink_phase)
  );

  // LED drive from current register values, so register writes show one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= data_q & {WIDTH{pwm_on}} & (~mode_q | {WIDTH{blink_phase}});
    end
  end

  assign out_port = out_q;

  // Read mux, zero-extended; write-only and unmapped addresses read 0
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
      ADDR_MODE:     readdata[WIDTH-1:0]      = mode_q;
      ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale_q;
      ADDR_DUTY:     readdata[DUTY_W-1:0]     = duty_q;
      default:       readdata                 = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_led_pwm.sv
// Directed bench for nios_led_pwm: register access, PWM duty, blink timing and resets.
module tb_nios_led_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nios_led_pwm #(
    .WIDTH         (8),
    .RESET_VALUE   (8'hA5),
    .PRESCALE_INIT (9),
    .PRESCALE_W    (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  // High cycles of out_port[0] over one full PWM period
  task automatic count_on(output int n);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (out_port[0]) n++;
    end
  endtask

  initial begin
    int   n;
    int   k;
    logic p;
    int   seq_a[9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    int   seq_b[7] = '{0, 0, 1, 1, 0, 0, 1};

    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    chk("rst out_port", {24'h0, out_port}, 32'hA5);
    rd("rst DATA", 3'd0, 32'hA5);
    rd("rst MODE", 3'd1, 32'h0);
    rd("rst PRESCALE", 3'd2, 32'd9);
    rd("rst DUTY", 3'd3, 32'hFF);

    // Set/clear
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'hF0);
    wr(3'd5, 32'h03);
    chk("setclr out before", {24'h0, out_port}, 32'hFF);
    tick(1);
    chk("setclr out after", {24'h0, out_port}, 32'hFC);
    rd("setclr DATA", 3'd0, 32'hFC);
    rd("OUTSET reads 0", 3'd4, 32'h0);
    rd("OUTCLR reads 0", 3'd5, 32'h0);

    // PWM
    wr(3'd0, 32'h01);
    wr(3'd3, 32'h40);
    rd("pwm DUTY", 3'd3, 32'h40);
    tick(1);
    count_on(n);
    chk("pwm 0x40 count", n, 64);
    wr(3'd3, 32'h00);
    tick(1);
    count_on(n);
    chk("pwm 0x00 count", n, 0);
    wr(3'd3, 32'h01);
    tick(1);
    count_on(n);
    chk("pwm 0x01 count", n, 1);
    wr(3'd3, 32'hFE);
    tick(1);
    count_on(n);
    chk("pwm 0xFE count", n, 254);
    wr(3'd3, 32'hFF);
    tick(1);
    count_on(n);
    chk("pwm 0xFF count", n, 256);

    // Blink: PRESCALE=3 restarts the count at the write edge
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h01);
    wr(3'd0, 32'h03);
    tick(1);
    p = out_port[0];
    chk("blink bit1 steady", {31'h0, out_port[1]}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk($sformatf("blink p3 step %0d", i), {30'h0, out_port[1:0]},
          {30'h0, 1'b1, (seq_a[i] != 0) ? p : ~p});
    end
    wr(3'd2, 32'd1);
    chk("blink rewrite edge", {30'h0, out_port[1:0]}, {30'h0, 1'b1, ~p});
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk($sformatf("blink p1 step %0d", i), {30'h0, out_port[1:0]},
          {30'h0, 1'b1, (seq_b[i] != 0) ? p : ~p});
    end

    // Boundary: unmapped writes, wide writedata, deselected write strobe
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd("addr6 reads 0", 3'd6, 32'h0);
    rd("addr7 reads 0", 3'd7, 32'h0);
    rd("bnd DATA kept", 3'd0, 32'h03);
    rd("bnd MODE kept", 3'd1, 32'h01);
    rd("bnd PRESCALE kept", 3'd2, 32'd1);
    rd("bnd DUTY kept", 3'd3, 32'hFF);
    wr(3'd0, 32'hFFFF_FF05);
    rd("wide wd DATA", 3'd0, 32'h05);
    address    = 3'd0;
    writedata  = 32'hAA;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick(1);
    write_n    = 1'b1;
    chipselect = 1'b1;
    tick(1);
    chipselect = 1'b0;
    rd("no-cs DATA kept", 3'd0, 32'h05);

    // Reset mid-blink while phase is 0
    wr(3'd2, 32'd5);
    k = 0;
    while (out_port[0] !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    while (out_port[0] !== 1'b0 && k < 40) begin
      tick(1);
      k++;
    end
    chk("mid wait for phase 0", {31'h0, k < 40}, 32'h1);
    tick(1);
    chk("mid pre-reset bit0", {31'h0, out_port[0]}, 32'h0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid rst out_port", {24'h0, out_port}, 32'hA5);
    rd("mid rst PRESCALE", 3'd2, 32'd9);
    rd("mid rst MODE", 3'd1, 32'h0);
    wr(3'd1, 32'h01);
    chk("mid blink start", {24'h0, out_port}, 32'hA5);
    for (int i = 2; i <= 11; i++) begin
      tick(1);
      chk($sformatf("mid blink edge %0d", i), {24'h0, out_port},
          (i < 11) ? 32'hA5 : 32'hA4);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
